// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an async FIFO read port.
// It pops one byte per frame and sends start, data LSB first, optional parity and stop.
// Tx_out is registered and goes idle high.

module fifo_uart_tx #(
    parameter int unsigned Data_width   = 8,
    parameter int unsigned Clks_per_bit = 4,
    parameter int unsigned Cnt_width    = 16
) (
    input  logic                  Rclk,
    input  logic                  Rrst,
    input  logic                  Rempty,
    input  logic [Data_width-1:0] Rdata,
    output logic                  Rinc,
    input  logic                  Tx_en,
    input  logic                  Par_en,
    input  logic                  Par_typ,
    output logic                  Tx_out,
    output logic                  Busy,
    output logic [Cnt_width-1:0]  Frame_cnt
);

    // Keep counters at least one bit wide so Clks_per_bit=1 or Data_width=1 still elaborate.
    localparam int unsigned PrescW = (Clks_per_bit > 1) ? $clog2(Clks_per_bit) : 1;
    localparam int unsigned BitW   = (Data_width > 1) ? $clog2(Data_width) : 1;

    localparam logic [PrescW-1:0] PrescLast = PrescW'(Clks_per_bit - 1);
    localparam logic [BitW-1:0]   BitLast   = BitW'(Data_width - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [Data_width-1:0] shift_q, shift_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [PrescW-1:0]     presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic [Cnt_width-1:0]  frame_cnt_q, frame_cnt_d;

    logic pop;
    logic bit_done;

    // Pop only from IDLE. The FIFO's late Rempty update then can never cause a second pop.
    assign pop      = (state_q == StIdle) & ~Rempty & Tx_en & ~Rrst;
    assign bit_done = (presc_q == PrescLast);

    // Next-state and datapath: tx_d always carries the level of the bit being entered.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        presc_d     = presc_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        tx_d        = tx_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                tx_d      = 1'b1;
                presc_d   = '0;
                bit_cnt_d = '0;
                if (pop) begin
                    // Frame options are frozen at the pop; later changes wait for the next frame.
                    shift_d   = Rdata;
                    par_en_d  = Par_en;
                    par_bit_d = (^Rdata) ^ Par_typ;
                    state_d   = StStart;
                    tx_d      = 1'b0;
                end
            end

            StStart: begin
                if (bit_done) begin
                    presc_d = '0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    presc_d = presc_q + PrescW'(1);
                end
            end

            StData: begin
                if (bit_done) begin
                    presc_d = '0;
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    presc_d = presc_q + PrescW'(1);
                end
            end

            StParity: begin
                if (bit_done) begin
                    presc_d = '0;
                    state_d = StStop;
                    tx_d    = 1'b1;
                end else begin
                    presc_d = presc_q + PrescW'(1);
                end
            end

            StStop: begin
                if (bit_done) begin
                    presc_d     = '0;
                    state_d     = StIdle;
                    tx_d        = 1'b1;
                    frame_cnt_d = frame_cnt_q + Cnt_width'(1);
                end else begin
                    presc_d = presc_q + PrescW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                presc_d = '0;
            end
        endcase
    end

    // State register. A synchronous reset aborts any frame; the popped byte is dropped.
    always_ff @(posedge Rclk) begin
        if (Rrst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            presc_q     <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            presc_q     <= presc_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            tx_q        <= tx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign Rinc      = pop;
    assign Tx_out    = tx_q;
    assign Busy      = (state_q != StIdle);
    assign Frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds the DUT, and a scoreboard holds expected frames.
// A line monitor checks every serial cycle of each frame against the scoreboard.

module tb_fifo_uart_tx;

    localparam int unsigned DW  = 8;
    localparam int unsigned CPB = 4;
    localparam int unsigned CW  = 16;

    logic          Rclk    = 1'b0;
    logic          Rrst    = 1'b1;
    logic          Rempty  = 1'b1;
    logic [DW-1:0] Rdata   = '0;
    logic          Tx_en   = 1'b1;
    logic          Par_en  = 1'b0;
    logic          Par_typ = 1'b0;
    logic          Rinc;
    logic          Tx_out;
    logic          Busy;
    logic [CW-1:0] Frame_cnt;

    fifo_uart_tx #(
        .Data_width  (DW),
        .Clks_per_bit(CPB),
        .Cnt_width   (CW)
    ) dut (
        .Rclk     (Rclk),
        .Rrst     (Rrst),
        .Rempty   (Rempty),
        .Rdata    (Rdata),
        .Rinc     (Rinc),
        .Tx_en    (Tx_en),
        .Par_en   (Par_en),
        .Par_typ  (Par_typ),
        .Tx_out   (Tx_out),
        .Busy     (Busy),
        .Frame_cnt(Frame_cnt)
    );

    always #5 Rclk = ~Rclk;

    // Expected frame: bit k is the k-th bit on the line (start first).
    typedef struct {
        logic [10:0] frame;
        int          nbits;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [10:0] frame;
        int          nbits;
    } vec_t;

    vec_t       tbl[9];
    exp_t       sb_q[$];
    logic [7:0] fifo_q[$];
    int         pop_cyc[$];

    int checks        = 0;
    int errors        = 0;
    int cyc           = 0;
    int pops          = 0;
    int rst_edges     = 0;
    int frames_done   = 0;
    int exp_frames    = 0;
    int mon_pops_seen = 0;
    int mon_rst_seen  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic pe, input logic pt);
        exp_t e;
        if (pe) begin
            e.frame = {1'b1, (^d) ^ pt, d, 1'b0};
            e.nbits = 11;
        end else begin
            e.frame = {1'b0, 1'b1, d, 1'b0};
            e.nbits = 10;
        end
        return e;
    endfunction

    task automatic push(input logic [7:0] d, input exp_t e);
        fifo_q.push_back(d);
        sb_q.push_back(e);
    endtask

    // FIFO read-port model: pop on Rinc, present the head with one-cycle Rempty latency.
    always @(posedge Rclk) begin
        cyc++;
        if (Rrst) rst_edges++;
        if (Rinc) begin
            pops++;
            pop_cyc.push_back(cyc);
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty got pop want none");
            end else begin
                void'(fifo_q.pop_front());
            end
        end
        Rempty <= (fifo_q.size() == 0);
        Rdata  <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // Walks one frame from the negedge after its pop edge; gives up on a reset edge.
    task automatic run_frame();
        exp_t e;
        int   n;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty got pop want no pop");
            e.frame = '1;
            e.nbits = 10;
        end else begin
            e = sb_q.pop_front();
        end
        n = e.nbits * CPB;
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge Rclk);
            if (rst_edges != mon_rst_seen) begin
                mon_rst_seen  = rst_edges;
                mon_pops_seen = pops;
                exp_frames    = 0;
                return;
            end
            check($sformatf("tx_bit%0d", j / CPB), 32'(Tx_out), 32'(e.frame[j / CPB]));
            check("busy_in_frame", 32'(Busy), 32'd1);
            check("rinc_in_frame", 32'(Rinc), 32'd0);
        end
        @(negedge Rclk);
        if (rst_edges != mon_rst_seen) begin
            mon_rst_seen  = rst_edges;
            mon_pops_seen = pops;
            exp_frames    = 0;
            return;
        end
        exp_frames++;
        check("tx_idle_after", 32'(Tx_out), 32'd1);
        check("busy_after", 32'(Busy), 32'd0);
        check("frame_cnt", 32'(Frame_cnt), 32'(exp_frames));
        frames_done++;
    endtask

    initial begin : monitor
        forever begin
            @(negedge Rclk);
            if (rst_edges != mon_rst_seen) begin
                mon_rst_seen  = rst_edges;
                mon_pops_seen = pops;
                exp_frames    = 0;
            end else if (pops != mon_pops_seen) begin
                mon_pops_seen = pops;
                run_frame();
            end
        end
    end

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pops < n && k < budget) begin
            @(negedge Rclk);
            k++;
        end
        check(name, 32'(pops >= n), 32'd1);
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge Rclk);
            k++;
        end
        check(name, 32'(frames_done >= n), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int fb;
        int sz;
        int k;

        // Hand-computed frames: {stop, parity, data, start}; 10-bit frames carry a zero MSB.
        tbl[0] = '{8'hA5, 1'b1, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        tbl[1] = '{8'hA5, 1'b1, 1'b1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11};
        tbl[2] = '{8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h01, 1'b0}, 11};
        tbl[3] = '{8'h01, 1'b1, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 11};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, {1'b1, 1'b0, 8'hFF, 1'b0}, 11};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 11};
        tbl[6] = '{8'h00, 1'b1, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 11};
        tbl[7] = '{8'h80, 1'b1, 1'b1, {1'b1, 1'b0, 8'h80, 1'b0}, 11};
        tbl[8] = '{8'h3C, 1'b0, 1'b0, {1'b0, 1'b1, 8'h3C, 1'b0}, 10};

        // Reset state
        Rrst = 1'b1;
        repeat (3) @(negedge Rclk);
        check("rst_tx", 32'(Tx_out), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_rinc", 32'(Rinc), 32'd0);
        check("rst_frame_cnt", 32'(Frame_cnt), 32'd0);
        Rrst = 1'b0;

        // Empty FIFO for 200 cycles
        for (int i = 0; i < 200; i++) begin
            @(negedge Rclk);
            check("empty_rinc", 32'(Rinc), 32'd0);
            check("empty_tx", 32'(Tx_out), 32'd1);
            check("empty_busy", 32'(Busy), 32'd0);
            check("empty_frame_cnt", 32'(Frame_cnt), 32'd0);
        end
        check("empty_pops", 32'(pops), 32'd0);

        // Single frames from the table; options are flipped mid-frame and must not matter
        for (int i = 0; i < 9; i++) begin
            @(negedge Rclk);
            Par_en  = tbl[i].pe;
            Par_typ = tbl[i].pt;
            base    = pops;
            fb      = frames_done;
            push(tbl[i].data, '{tbl[i].frame, tbl[i].nbits});
            wait_pops(base + 1, 20, "vec_pop");
            Par_en  = ~tbl[i].pe;
            Par_typ = ~tbl[i].pt;
            wait_frames(fb + 1, 100, "vec_frame");
        end

        // Three queued bytes, no parity: back-to-back with a 41-cycle pop spacing
        @(negedge Rclk);
        Par_en = 1'b0;
        base   = pops;
        fb     = frames_done;
        push(8'h11, '{{1'b0, 1'b1, 8'h11, 1'b0}, 10});
        push(8'h22, '{{1'b0, 1'b1, 8'h22, 1'b0}, 10});
        push(8'h33, '{{1'b0, 1'b1, 8'h33, 1'b0}, 10});
        wait_frames(fb + 3, 200, "b2b_frames");
        repeat (10) @(negedge Rclk);
        check("b2b_pops", 32'(pops - base), 32'd3);
        sz = pop_cyc.size();
        check("b2b_gap1", 32'(pop_cyc[sz-2] - pop_cyc[sz-3]), 32'd41);
        check("b2b_gap2", 32'(pop_cyc[sz-1] - pop_cyc[sz-2]), 32'd41);
        check("b2b_rempty", 32'(Rempty), 32'd1);
        check("b2b_busy", 32'(Busy), 32'd0);
        check("b2b_tx", 32'(Tx_out), 32'd1);
        check("b2b_frame_cnt", 32'(Frame_cnt), 32'(exp_frames));

        // Tx_en dropped during DATA: first frame completes, second waits for Tx_en
        @(negedge Rclk);
        Par_en  = 1'b1;
        Par_typ = 1'b1;
        Tx_en   = 1'b1;
        base    = pops;
        fb      = frames_done;
        push(8'h5A, model(8'h5A, 1'b1, 1'b1));
        push(8'hC3, model(8'hC3, 1'b1, 1'b1));
        wait_pops(base + 1, 20, "txen_pop1");
        repeat (2 * CPB + 1) @(negedge Rclk);
        Tx_en = 1'b0;
        wait_frames(fb + 1, 60, "txen_frame1");
        repeat (100) @(negedge Rclk);
        check("txen_hold_pops", 32'(pops), 32'(base + 1));
        check("txen_hold_busy", 32'(Busy), 32'd0);
        check("txen_hold_tx", 32'(Tx_out), 32'd1);
        check("txen_hold_rempty", 32'(Rempty), 32'd0);
        check("txen_hold_frame_cnt", 32'(Frame_cnt), 32'(exp_frames));
        Tx_en = 1'b1;
        wait_frames(fb + 2, 80, "txen_frame2");
        check("txen_pops", 32'(pops), 32'(base + 2));

        // Reset during the third data bit: frame aborted, next byte sent in full
        @(negedge Rclk);
        Par_en = 1'b0;
        base   = pops;
        fb     = frames_done;
        push(8'h96, model(8'h96, 1'b0, 1'b0));
        push(8'h4B, model(8'h4B, 1'b0, 1'b0));
        wait_pops(base + 1, 20, "rst_pop1");
        k = 0;
        while ((cyc - pop_cyc[pop_cyc.size()-1]) < 13 && k < 40) begin
            @(negedge Rclk);
            k++;
        end
        check("rst_align", 32'(cyc - pop_cyc[pop_cyc.size()-1]), 32'd13);
        Rrst = 1'b1;
        @(negedge Rclk);
        check("midrst_tx", 32'(Tx_out), 32'd1);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_frame_cnt", 32'(Frame_cnt), 32'd0);
        check("midrst_rinc", 32'(Rinc), 32'd0);
        Rrst = 1'b0;
        wait_frames(fb + 1, 80, "rst_frame2");
        check("rst_frame_cnt_after", 32'(Frame_cnt), 32'd1);
        check("rst_pops", 32'(pops), 32'(base + 2));
        repeat (5) @(negedge Rclk);
        check("rst_rempty", 32'(Rempty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
